mgmt_burst_bridge: RTL and testbench

- Parametrised successor to the single-word HPS management handshake in the emu top level.
- Accepts read/write commands from the HPS extension side (hps_ext) and turns them into Avalon-MM burst transfers on the system mgmt slave.
- Buffers write data so the Avalon burst is never stalled by the host.
- Adds configurable burst length, a bus timeout and error reporting.

---
 rtl/mgmt_burst_bridge_if.sv | 52 +++++
 rtl/mgmt_burst_bridge.sv | 154 +++++++++++++++
 tb/tb_mgmt_burst_bridge.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/mgmt_burst_bridge_if.sv
// Host-side command/data bus and Avalon-MM master bus used by mgmt_burst_bridge.
// The bridge takes the slave end of the host bus and the master end of the Avalon bus.
interface mgmt_host_if #(
    parameter int DW = 32,
    parameter int AW = 32,
    parameter int LW = 4
);
    logic [AW-1:0] host_addr;
    logic [LW-1:0] host_len;
    logic          host_rd;
    logic          host_wr;
    logic [DW-1:0] host_wdata;
    logic          host_wvalid;
    logic [DW-1:0] host_rdata;
    logic          host_rvalid;
    logic          host_wait;
    logic          host_err;

    modport master (
        output host_addr, host_len, host_rd, host_wr, host_wdata, host_wvalid,
        input  host_rdata, host_rvalid, host_wait, host_err
    );
    modport slave (
        input  host_addr, host_len, host_rd, host_wr, host_wdata, host_wvalid,
        output host_rdata, host_rvalid, host_wait, host_err
    );
endinterface

interface avmm_if #(
    parameter int DW = 32,
    parameter int AW = 32,
    parameter int LW = 4
);
    logic [AW-1:0]   avm_address;
    logic            avm_read;
    logic            avm_write;
    logic [DW-1:0]   avm_writedata;
    logic [DW/8-1:0] avm_byteenable;
    logic [LW-1:0]   avm_burstcount;
    logic            avm_waitrequest;
    logic [DW-1:0]   avm_readdata;
    logic            avm_readdatavalid;

    modport master (
        output avm_address, avm_read, avm_write, avm_writedata, avm_byteenable, avm_burstcount,
        input  avm_waitrequest, avm_readdata, avm_readdatavalid
    );
    modport slave (
        input  avm_address, avm_read, avm_write, avm_writedata, avm_byteenable, avm_burstcount,
        output avm_waitrequest, avm_readdata, avm_readdatavalid
    );
endinterface

// File: rtl/mgmt_burst_bridge.sv
// Turns host read/write commands into Avalon-MM bursts; write data is staged in a
// local buffer first so the Avalon burst never waits on the host.
module mgmt_burst_bridge #(
    parameter int DW        = 32,
    parameter int AW        = 32,
    parameter int MAX_BURST = 8,
    parameter int TIMEOUT   = 65535
) (
    input  logic         clk_sys,
    input  logic         reset,
    mgmt_host_if.slave   host,
    avmm_if.master       avm
);
    localparam int LW = $clog2(MAX_BURST) + 1;
    localparam int IW = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {IDLE, RD_REQ, RD_DATA, WR_FILL, WR_BURST, DONE} state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [LW-1:0] len_q, len_d;
    logic [LW-1:0] cnt_q, cnt_d;
    logic [TW-1:0] to_q, to_d;
    logic          err_q, err_d;
    logic          rvalid_q, rvalid_d;
    logic [DW-1:0] rdata_q, rdata_d;
    logic [DW-1:0] buf_mem [MAX_BURST];
    logic          buf_we;

    logic [LW-1:0] cnt_inc;
    logic          len_ok, active, progress, timed_out;
    logic          req_acc, rd_beat, wr_beat, fill_beat;

    // cnt_q is LW bits wide so a full MAX_BURST count never aliases to zero
    assign cnt_inc   = cnt_q + 1'b1;
    assign len_ok    = (host.host_len != '0) && (host.host_len <= LW'(MAX_BURST));
    assign req_acc   = (state_q == RD_REQ)   && !avm.avm_waitrequest;
    assign rd_beat   = (state_q == RD_DATA)  && avm.avm_readdatavalid;
    assign wr_beat   = (state_q == WR_BURST) && !avm.avm_waitrequest;
    assign fill_beat = (state_q == WR_FILL)  && host.host_wvalid;
    assign progress  = req_acc | rd_beat | wr_beat | fill_beat;
    assign active    = (state_q == RD_REQ) || (state_q == RD_DATA) ||
                       (state_q == WR_FILL) || (state_q == WR_BURST);
    assign timed_out = active && !progress && (to_q == TW'(TIMEOUT - 1));

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        len_d    = len_q;
        cnt_d    = cnt_q;
        err_d    = err_q;
        rvalid_d = 1'b0;
        rdata_d  = rdata_q;
        buf_we   = 1'b0;
        to_d     = '0;

        case (state_q)
            IDLE: begin
                if (host.host_rd || host.host_wr) begin
                    addr_d = host.host_addr;
                    len_d  = host.host_len;
                    cnt_d  = '0;
                    err_d  = !len_ok;
                    if (!len_ok)          state_d = DONE;
                    else if (host.host_rd) state_d = RD_REQ;
                    else                   state_d = WR_FILL;
                end
            end
            RD_REQ: begin
                if (req_acc) state_d = RD_DATA;
            end
            RD_DATA: begin
                if (rd_beat) begin
                    rdata_d  = avm.avm_readdata;
                    rvalid_d = 1'b1;
                    cnt_d    = cnt_inc;
                    if (cnt_inc == len_q) state_d = DONE;
                end
            end
            WR_FILL: begin
                if (fill_beat) begin
                    buf_we = 1'b1;
                    cnt_d  = cnt_inc;
                    if (cnt_inc == len_q) begin
                        state_d = WR_BURST;
                        cnt_d   = '0;
                    end
                end
            end
            WR_BURST: begin
                if (wr_beat) begin
                    cnt_d = cnt_inc;
                    if (cnt_inc == len_q) state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        if (timed_out) begin
            state_d = DONE;
            err_d   = 1'b1;
        end

        // Watchdog restarts on every state change and every unit of bus/host progress
        if (active && !progress && (state_d == state_q))
            to_d = to_q + 1'b1;
    end

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            addr_q   <= '0;
            len_q    <= '0;
            cnt_q    <= '0;
            to_q     <= '0;
            err_q    <= 1'b0;
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            len_q    <= len_d;
            cnt_q    <= cnt_d;
            to_q     <= to_d;
            err_q    <= err_d;
            rvalid_q <= rvalid_d;
            rdata_q  <= rdata_d;
        end
    end

    always_ff @(posedge clk_sys) begin
        if (buf_we) buf_mem[cnt_q[IW-1:0]] <= host.host_wdata;
    end

    // Bus outputs decode straight from state so an asynchronous reset clears them at once
    logic req_rd, req_wr, req_any;
    assign req_rd  = (state_q == RD_REQ);
    assign req_wr  = (state_q == WR_BURST);
    assign req_any = req_rd | req_wr;

    assign avm.avm_read       = req_rd;
    assign avm.avm_write      = req_wr;
    assign avm.avm_address    = req_any ? addr_q : '0;
    assign avm.avm_burstcount = req_any ? len_q : '0;
    assign avm.avm_byteenable = req_any ? '1 : '0;
    assign avm.avm_writedata  = req_wr ? buf_mem[cnt_q[IW-1:0]] : '0;

    assign host.host_rdata  = rdata_q;
    assign host.host_rvalid = rvalid_q;
    assign host.host_wait   = (state_q != IDLE);
    assign host.host_err    = err_q;
endmodule

// File: tb/tb_mgmt_burst_bridge.sv
// Directed bench for mgmt_burst_bridge: reads, a full-length write burst, length
// errors, timeout abort, command collisions and asynchronous reset mid-burst.
module tb_mgmt_burst_bridge;
    localparam int DW = 32;
    localparam int AW = 32;
    localparam int LW = 4;

    logic clk;
    logic rst;
    int   n_tests = 0;
    int   n_fail  = 0;
    int   nb;
    logic wq;

    mgmt_host_if #(.DW(DW), .AW(AW), .LW(LW)) h ();
    avmm_if      #(.DW(DW), .AW(AW), .LW(LW)) a ();

    mgmt_burst_bridge #(.DW(DW), .AW(AW), .MAX_BURST(8), .TIMEOUT(16)) dut (
        .clk_sys (clk),
        .reset   (rst),
        .host    (h),
        .avm     (a)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        h.host_addr = '0; h.host_len = '0; h.host_rd = 1'b0; h.host_wr = 1'b0;
        h.host_wdata = '0; h.host_wvalid = 1'b0;
        a.avm_waitrequest = 1'b0; a.avm_readdata = '0; a.avm_readdatavalid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_read",   a.avm_read, 0);
        chk("rst_write",  a.avm_write, 0);
        chk("rst_addr",   a.avm_address, 0);
        chk("rst_be",     a.avm_byteenable, 0);
        chk("rst_bc",     a.avm_burstcount, 0);
        chk("rst_wait",   h.host_wait, 0);
        chk("rst_err",    h.host_err, 0);
        chk("rst_rvalid", h.host_rvalid, 0);
        rst = 1'b0;
        cyc();

        // Read len=1 with three stall cycles
        h.host_addr = 32'h100; h.host_len = 1; h.host_rd = 1'b1; a.avm_waitrequest = 1'b1;
        cyc();
        h.host_rd = 1'b0;
        chk("t1_addr", a.avm_address, 32'h100);
        chk("t1_be",   a.avm_byteenable, 4'hF);
        chk("t1_wait", h.host_wait, 1);
        for (int i = 0; i < 4; i++) begin
            a.avm_waitrequest = (i < 3);
            chk("t1_read_held", a.avm_read, 1);
            chk("t1_bc", a.avm_burstcount, 1);
            cyc();
        end
        a.avm_waitrequest = 1'b0;
        chk("t1_read_drop", a.avm_read, 0);
        a.avm_readdatavalid = 1'b1; a.avm_readdata = 32'hDEADBEEF;
        cyc();
        a.avm_readdatavalid = 1'b0;
        chk("t1_rvalid", h.host_rvalid, 1);
        chk("t1_rdata",  h.host_rdata, 32'hDEADBEEF);
        chk("t1_wait_done", h.host_wait, 1);
        chk("t1_err", h.host_err, 0);
        cyc();
        chk("t1_rvalid_end", h.host_rvalid, 0);
        chk("t1_wait_low", h.host_wait, 0);

        // Write len=8 with gaps in host data and toggling waitrequest
        h.host_addr = 32'h2000; h.host_len = 8; h.host_wr = 1'b1;
        h.host_wvalid = 1'b1; h.host_wdata = 32'hBAD;
        cyc();
        h.host_wr = 1'b0; h.host_wvalid = 1'b0;
        chk("t2_fill_wait", h.host_wait, 1);
        for (int i = 0; i < 8; i++) begin
            h.host_wvalid = 1'b1; h.host_wdata = i;
            chk("t2_fill_nowrite", a.avm_write, 0);
            cyc();
            h.host_wvalid = 1'b0;
            if ((i % 2 == 0) && (i < 7)) cyc();
        end
        chk("t2_write_start", a.avm_write, 1);
        nb = 0; wq = 1'b1;
        for (int k = 0; k < 40 && a.avm_write; k++) begin
            a.avm_waitrequest = wq;
            chk("t2_bc", a.avm_burstcount, 8);
            chk("t2_addr", a.avm_address, 32'h2000);
            if (!wq) begin
                chk("t2_beat_data", a.avm_writedata, nb);
                nb++;
            end
            wq = !wq;
            cyc();
        end
        a.avm_waitrequest = 1'b0;
        chk("t2_beats", nb, 8);
        chk("t2_write_end", a.avm_write, 0);
        chk("t2_done_wait", h.host_wait, 1);
        chk("t2_err", h.host_err, 0);
        cyc();
        chk("t2_wait_low", h.host_wait, 0);

        // Illegal lengths: 0 (write) then 9 (read)
        h.host_addr = 32'h40; h.host_len = 0; h.host_wr = 1'b1;
        cyc();
        h.host_wr = 1'b0;
        chk("t3a_wait", h.host_wait, 1);
        chk("t3a_err", h.host_err, 1);
        chk("t3a_nowrite", a.avm_write, 0);
        cyc();
        chk("t3a_wait_low", h.host_wait, 0);
        chk("t3a_err_sticky", h.host_err, 1);
        chk("t3a_nowrite2", a.avm_write, 0);
        h.host_len = 9; h.host_rd = 1'b1;
        cyc();
        h.host_rd = 1'b0;
        chk("t3b_wait", h.host_wait, 1);
        chk("t3b_err", h.host_err, 1);
        chk("t3b_noread", a.avm_read, 0);
        cyc();
        chk("t3b_wait_low", h.host_wait, 0);
        chk("t3b_noread2", a.avm_read, 0);

        // Read len=4, slave returns only two beats, then a late third beat
        h.host_addr = 32'h300; h.host_len = 4; h.host_rd = 1'b1;
        cyc();
        h.host_rd = 1'b0;
        chk("t4_err_cleared", h.host_err, 0);
        chk("t4_bc", a.avm_burstcount, 4);
        cyc();
        a.avm_readdatavalid = 1'b1; a.avm_readdata = 32'hA1;
        cyc();
        chk("t4_rv1", h.host_rvalid, 1);
        chk("t4_rd1", h.host_rdata, 32'hA1);
        a.avm_readdata = 32'hA2;
        cyc();
        a.avm_readdatavalid = 1'b0;
        chk("t4_rv2", h.host_rvalid, 1);
        chk("t4_rd2", h.host_rdata, 32'hA2);
        for (int i = 1; i <= 16; i++) begin
            chk("t4_pending_err", h.host_err, 0);
            chk("t4_pending_wait", h.host_wait, 1);
            cyc();
        end
        chk("t4_abort_err", h.host_err, 1);
        chk("t4_abort_wait", h.host_wait, 1);
        cyc();
        chk("t4_idle_wait", h.host_wait, 0);
        a.avm_readdatavalid = 1'b1; a.avm_readdata = 32'hA3;
        cyc();
        a.avm_readdatavalid = 1'b0;
        chk("t4_late_rvalid", h.host_rvalid, 0);
        chk("t4_late_rdata", h.host_rdata, 32'hA2);

        // Simultaneous rd+wr, then another rd while busy
        h.host_addr = 32'h400; h.host_len = 2; h.host_rd = 1'b1; h.host_wr = 1'b1;
        a.avm_waitrequest = 1'b1;
        cyc();
        h.host_wr = 1'b0;
        h.host_addr = 32'h500; h.host_len = 1;
        chk("t5_read", a.avm_read, 1);
        chk("t5_nowrite", a.avm_write, 0);
        chk("t5_err", h.host_err, 0);
        cyc();
        h.host_rd = 1'b0; a.avm_waitrequest = 1'b0;
        chk("t5_addr_kept", a.avm_address, 32'h400);
        chk("t5_bc_kept", a.avm_burstcount, 2);
        cyc();
        a.avm_readdatavalid = 1'b1; a.avm_readdata = 32'h11;
        cyc();
        a.avm_readdata = 32'h22;
        chk("t5_rd1", h.host_rdata, 32'h11);
        cyc();
        a.avm_readdatavalid = 1'b0;
        chk("t5_rv2", h.host_rvalid, 1);
        chk("t5_rd2", h.host_rdata, 32'h22);
        cyc();
        chk("t5_wait_low", h.host_wait, 0);
        cyc();
        chk("t5_no_second_read", a.avm_read, 0);
        chk("t5_still_idle", h.host_wait, 0);

        // Reset during a write burst after three accepted beats
        h.host_addr = 32'h600; h.host_len = 4; h.host_wr = 1'b1;
        cyc();
        h.host_wr = 1'b0;
        for (int i = 0; i < 4; i++) begin
            h.host_wvalid = 1'b1; h.host_wdata = 32'h60 + i;
            cyc();
        end
        h.host_wvalid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("t6_beat", a.avm_writedata, 32'h60 + i);
            cyc();
        end
        chk("t6_fourth_pending", a.avm_write, 1);
        #2;
        rst = 1'b1;
        #1;
        chk("t6_rst_write", a.avm_write, 0);
        chk("t6_rst_addr", a.avm_address, 0);
        chk("t6_rst_bc", a.avm_burstcount, 0);
        chk("t6_rst_be", a.avm_byteenable, 0);
        chk("t6_rst_wdata", a.avm_writedata, 0);
        chk("t6_rst_wait", h.host_wait, 0);
        cyc();
        chk("t6_rst_rvalid", h.host_rvalid, 0);
        rst = 1'b0;
        h.host_addr = 32'h700; h.host_len = 2; h.host_rd = 1'b1;
        cyc();
        h.host_rd = 1'b0;
        chk("t6_rd_addr", a.avm_address, 32'h700);
        chk("t6_rd_bc", a.avm_burstcount, 2);
        cyc();
        a.avm_readdatavalid = 1'b1; a.avm_readdata = 32'h55;
        cyc();
        a.avm_readdata = 32'h66;
        chk("t6_rd1", h.host_rdata, 32'h55);
        cyc();
        a.avm_readdatavalid = 1'b0;
        chk("t6_rv2", h.host_rvalid, 1);
        chk("t6_rd2", h.host_rdata, 32'h66);
        cyc();
        chk("t6_wait_low", h.host_wait, 0);
        chk("t6_err", h.host_err, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
